uart_receiver: RTL and testbench

Receive-side UART stage that deserialises an 8N1 asynchronous serial line (idle high, LSB first) into parallel words. It is the downstream counterpart of the UART transmitter: it consumes the TX line and runs at the same bit rate (434 clocks/bit, i.e. 115200 baud at 50 MHz). Each accepted word is presented on a parallel output with a one-cycle valid strobe. Malformed frames are flagged with a one-cycle error strobe.

---
 rtl/uart_receiver.sv | 144 ++++++++++++++
 tb/tb_uart_receiver.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: synchronises the serial line, samples each bit near its centre and
// presents complete words with a one-cycle valid strobe, or a one-cycle frame-error strobe.
module uart_receiver #(
  parameter int unsigned DATA_WIDTH          = 8,
  parameter int unsigned BIT_COUNTER_WIDTH   = 3,
  parameter int unsigned CLOCK_COUNTER_WIDTH = 9,
  parameter int unsigned CLOCKS_PER_BIT      = 434
) (
  input  logic                  i_clock,
  input  logic                  i_resetL,
  input  logic                  i_RX,
  output logic [DATA_WIDTH-1:0] o_value,
  output logic                  o_valid,
  output logic                  o_frame_error,
  output logic                  o_busy
);

  localparam int unsigned HalfBit = CLOCKS_PER_BIT / 2;

  localparam logic [CLOCK_COUNTER_WIDTH-1:0] StartSample =
    CLOCK_COUNTER_WIDTH'(HalfBit - 1);
  localparam logic [CLOCK_COUNTER_WIDTH-1:0] BitSample =
    CLOCK_COUNTER_WIDTH'(CLOCKS_PER_BIT - 1);
  localparam logic [BIT_COUNTER_WIDTH-1:0] LastBit = BIT_COUNTER_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } state_e;

  state_e                         state_q, state_d;
  logic                           rx_meta_q, rx_sync_q;
  logic [CLOCK_COUNTER_WIDTH-1:0] clk_cnt_q, clk_cnt_d;
  logic [BIT_COUNTER_WIDTH-1:0]   bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0]          shift_q, shift_d;
  logic [DATA_WIDTH-1:0]          value_q, value_d;
  logic                           valid_q, valid_d;
  logic                           frame_error_q, frame_error_d;

  // Synchroniser idles high so reset never looks like a start bit.
  always_ff @(posedge i_clock or negedge i_resetL) begin
    if (!i_resetL) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= i_RX;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_ff @(posedge i_clock or negedge i_resetL) begin
    if (!i_resetL) begin
      state_q       <= StIdle;
      clk_cnt_q     <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      value_q       <= '0;
      valid_q       <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clk_cnt_q     <= clk_cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      value_q       <= value_d;
      valid_q       <= valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    clk_cnt_d     = clk_cnt_q + CLOCK_COUNTER_WIDTH'(1);
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    value_d       = value_q;
    valid_d       = 1'b0;
    frame_error_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!rx_sync_q) begin
          state_d   = StStart;
          clk_cnt_d = '0;
        end
      end
      StStart: begin
        // A line that is high again at mid start bit was only a glitch.
        if (clk_cnt_q == StartSample) begin
          clk_cnt_d = '0;
          if (!rx_sync_q) begin
            state_d   = StData;
            bit_idx_d = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (clk_cnt_q == BitSample) begin
          clk_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[DATA_WIDTH-1:1]};
          if (bit_idx_q == LastBit) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + BIT_COUNTER_WIDTH'(1);
          end
        end
      end
      StStop: begin
        if (clk_cnt_q == BitSample) begin
          clk_cnt_d = '0;
          if (rx_sync_q) begin
            value_d = shift_q;
            valid_d = 1'b1;
            state_d = StIdle;
          end else begin
            frame_error_d = 1'b1;
            state_d       = StWaitHigh;
          end
        end
      end
      StWaitHigh: begin
        // Hold off until the line recovers so a break reports only once.
        if (rx_sync_q) begin
          state_d   = StIdle;
          clk_cnt_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign o_value       = value_q;
  assign o_valid       = valid_q;
  assign o_frame_error = frame_error_q;
  assign o_busy        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: a pre-built random/directed line schedule, a frame-level model that
// predicts every output cycle, a per-cycle compare process and a few hand-computed pins.
module tb_uart_receiver;

  localparam int N    = 434;
  localparam int H    = N / 2;
  localparam int MAXT = 80000;

  logic       clk = 1'b0;
  logic       rst_l;
  logic       rx;
  logic [7:0] value;
  logic       valid, ferr, busy;

  always #5 clk = ~clk;

  uart_receiver #(
    .DATA_WIDTH         (8),
    .BIT_COUNTER_WIDTH  (3),
    .CLOCK_COUNTER_WIDTH(9),
    .CLOCKS_PER_BIT     (N)
  ) dut (
    .i_clock      (clk),
    .i_resetL     (rst_l),
    .i_RX         (rx),
    .o_value      (value),
    .o_valid      (valid),
    .o_frame_error(ferr),
    .o_busy       (busy)
  );

  // Index t = value at / after rising edge t.
  bit       line_a   [MAXT];
  bit       rst_a    [MAXT];
  bit       exp_valid[MAXT];
  bit       exp_err  [MAXT];
  bit       exp_busy [MAXT];
  logic [7:0] exp_val[MAXT];
  logic [7:0] vval   [MAXT];

  int wp = 0;
  int T;
  int cur = 0;
  bit active = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int dut_valid_cnt = 0, dut_err_cnt = 0, first_valid_t = -1;
  logic [7:0] first_valid_v = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  task automatic put(input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      if (wp < MAXT) begin
        line_a[wp] = v;
        rst_a[wp]  = 1'b0;
        wp++;
      end
    end
  endtask

  function automatic int blen(input bit jit);
    return jit ? N - 1 + int'($urandom_range(0, 2)) : N;
  endfunction

  task automatic frame(input logic [7:0] b, input bit stop, input int extra, input bit jit,
                       output int start);
    start = wp;
    put(1'b0, blen(jit));
    for (int i = 0; i < 8; i++) put(b[i], blen(jit));
    put(stop, blen(jit));
    put(1'b0, extra);
  endtask

  function automatic bit lineeff(input int t);
    if (t < 0 || t >= T) return 1'b1;
    return rst_a[t] ? 1'b1 : line_a[t];
  endfunction

  function automatic int first_rst(input int a, input int b);
    for (int t = a; t <= b && t < T; t++) if (rst_a[t]) return t;
    return -1;
  endfunction

  function automatic int release_after(input int r);
    int q = r;
    while (q < T && rst_a[q]) q++;
    return q - 1;
  endfunction

  task automatic mark_busy(input int a, input int b);
    for (int t = a; t <= b && t < T; t++) if (t >= 0) exp_busy[t] = 1'b1;
  endtask

  // Frame-level model: each frame is judged from line values at fixed offsets from its start.
  task automatic run_model();
    int t0, k, ds, d, r, j;
    logic [7:0] w, v;
    t0 = release_after(0);
    while (1) begin
      k = t0;
      while (k < T && lineeff(k)) k++;
      ds = k + 2 + H;
      if (ds >= T) break;
      r = first_rst(k + 1, ds);
      if (r >= 0) begin mark_busy(k + 2, r - 1); t0 = release_after(r); continue; end
      if (lineeff(k + H)) begin mark_busy(k + 2, ds - 1); t0 = ds - 1; continue; end
      d = k + 2 + H + 9 * N;
      if (d >= T) begin mark_busy(k + 2, T - 1); break; end
      r = first_rst(k + 1, d);
      if (r >= 0) begin mark_busy(k + 2, r - 1); t0 = release_after(r); continue; end
      for (int i = 0; i < 8; i++) w[i] = lineeff(k + H + (i + 1) * N);
      mark_busy(k + 2, d - 1);
      if (lineeff(k + H + 9 * N)) begin
        exp_valid[d] = 1'b1;
        vval[d]      = w;
        t0           = d - 1;
      end else begin
        exp_err[d] = 1'b1;
        j = d - 1;
        while (j < T && !lineeff(j)) j++;
        r = first_rst(d + 1, j + 1);
        if (r >= 0) begin mark_busy(d, r - 1); t0 = release_after(r); continue; end
        mark_busy(d, j + 1);
        if (j + 2 >= T) break;
        t0 = j + 1;
      end
    end
    v = 8'h00;
    for (int t = 0; t < T; t++) begin
      if (rst_a[t]) v = 8'h00;
      else if (exp_valid[t]) v = vval[t];
      exp_val[t] = v;
    end
  endtask

  // Per-cycle compare against the model.
  initial begin
    logic [10:0] act, req;
    forever begin
      @(negedge clk);
      if (active) begin
        act = {valid, ferr, busy, value};
        req = {exp_valid[cur], exp_err[cur], exp_busy[cur], exp_val[cur]};
        n_cmp++;
        if (act !== req) begin
          n_bad++;
          if (n_bad <= 40)
            $display("FAIL cycle %0d {valid,err,busy,value}: got 0x%0h, want 0x%0h", cur, act, req);
        end
        if (valid === 1'b1) begin
          dut_valid_cnt++;
          if (first_valid_t < 0) begin first_valid_t = cur; first_valid_v = value; end
        end
        if (ferr === 1'b1) dut_err_cnt++;
      end
    end
  end

  initial begin
    int s_a5, s00, sff, sg, s11, s3c, s5a, sc3, r0, jhigh, st, mv, me;
    int s_lb[5];
    logic [7:0] lb[5];
    lb[0] = 8'h00; lb[1] = 8'h55; lb[2] = 8'hAA; lb[3] = 8'hFF; lb[4] = 8'h7E;

    put(1'b1, 4);
    for (int i = 0; i < 4; i++) rst_a[i] = 1'b1;
    put(1'b1, 20);
    frame(8'hA5, 1'b1, 0, 1'b0, s_a5);   put(1'b1, 50);
    frame(8'h00, 1'b1, 0, 1'b0, s00);
    frame(8'hFF, 1'b1, 0, 1'b0, sff);    put(1'b1, 30);
    sg = wp; put(1'b0, 100);             put(1'b1, 400);
    frame(8'h11, 1'b1, 0, 1'b0, s11);
    frame(8'h3C, 1'b0, 5 * N, 1'b0, s3c); put(1'b1, 50);
    frame(8'h5A, 1'b1, 0, 1'b0, s5a);
    r0 = s5a + 5 * N + 100;
    for (int t = r0; t < wp; t++) line_a[t] = 1'b1;
    for (int i = 0; i < 3; i++) rst_a[r0 + i] = 1'b1;
    put(1'b1, 200);
    frame(8'hC3, 1'b1, 0, 1'b0, sc3);    put(1'b1, 50);
    for (int i = 0; i < 5; i++) begin frame(lb[i], 1'b1, 0, 1'b0, s_lb[i]); put(1'b1, 50); end
    for (int i = 0; i < 3; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        put(1'b0, int'($urandom_range(1, 150)));
        put(1'b1, int'($urandom_range(300, 500)));
      end
      frame(8'($urandom), ($urandom_range(0, 3) != 0), int'($urandom_range(0, 600)), 1'b1, st);
      put(1'b1, int'($urandom_range(1, 60)));
    end
    put(1'b1, 50);
    T = wp;
    run_model();

    rx    = line_a[0];
    rst_l = ~rst_a[0];
    for (int t = 0; t < T; t++) begin
      @(posedge clk);
      cur    = t;
      active = 1'b1;
      @(negedge clk);
      #1;
      if (t + 1 < T) begin
        rx    = line_a[t + 1];
        rst_l = ~rst_a[t + 1];
      end
    end
    active = 1'b0;

    // Hand-computed pins on the model and on observed DUT behaviour.
    chk("a5_model_valid_at_k4125", 32'(exp_valid[s_a5 + 4125]), 32'd1);
    chk("a5_model_value", 32'(vval[s_a5 + 4125]), 32'hA5);
    chk("a5_model_busy_drop", 32'(exp_busy[s_a5 + 4125]), 32'd0);
    chk("a5_dut_first_valid_edge", 32'(first_valid_t), 32'(s_a5 + 4125));
    chk("a5_dut_first_value", 32'(first_valid_v), 32'hA5);
    chk("b2b_first_value", 32'(exp_valid[s00 + 4125] ? vval[s00 + 4125] : 8'hEE), 32'h00);
    chk("b2b_second_10N_later", 32'(exp_valid[s00 + 4125 + 10 * N]), 32'd1);
    chk("b2b_second_value", 32'(vval[sff + 4125]), 32'hFF);
    chk("glitch_busy_last", 32'(exp_busy[sg + 2 + 216]), 32'd1);
    chk("glitch_busy_clear", 32'(exp_busy[sg + 2 + 217]), 32'd0);
    chk("ferr_model_pulse", 32'(exp_err[s3c + 4125]), 32'd1);
    chk("ferr_value_kept", 32'(exp_val[s3c + 4125]), 32'h11);
    jhigh = s3c + 15 * N;
    chk("ferr_busy_held", 32'(exp_busy[jhigh + 1]), 32'd1);
    chk("ferr_busy_release", 32'(exp_busy[jhigh + 2]), 32'd0);
    chk("reset_busy_before", 32'(exp_busy[r0 - 1]), 32'd1);
    chk("reset_clears", 32'({exp_busy[r0], exp_val[r0]}), 32'd0);
    chk("after_reset_c3", 32'(vval[sc3 + 4125]), 32'hC3);
    for (int i = 0; i < 5; i++)
      chk($sformatf("loopback_%0d", i),
          32'(exp_valid[s_lb[i] + 4125] ? vval[s_lb[i] + 4125] : 8'hEE), 32'(lb[i]));
    mv = 0; me = 0;
    for (int t = 0; t < T; t++) begin mv += int'(exp_valid[t]); me += int'(exp_err[t]); end
    chk("dut_valid_count", 32'(dut_valid_cnt), 32'(mv));
    chk("dut_err_count", 32'(dut_err_cnt), 32'(me));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
